// File: rtl/disp_pkg.sv
// Shared types, constants and helpers for the 4-digit display scanner.
package disp_pkg;

    typedef enum logic {
        SHOW  = 1'b0,
        GHOST = 1'b1
    } state_e;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [3:0] AN_RST  = 4'b1110;
    localparam logic [3:0] LES_RST = 4'b1111;

    // One complete display word: nibbles, decimal points and blank requests.
    typedef struct packed {
        logic [15:0] hexs;
        logic [3:0]  points;
        logic [3:0]  les;
    } disp_word_t;

    // Bit i set when digit i is a leading zero (digits i..3 all zero); digit 0 never.
    function automatic logic [3:0] lz_mask(input logic [15:0] hex16);
        logic [3:0] m;
        m[0] = 1'b0;
        m[1] = (hex16[15:4]  == 12'h000);
        m[2] = (hex16[15:8]  == 8'h00);
        m[3] = (hex16[15:12] == 4'h0);
        return m;
    endfunction

endpackage

// File: rtl/disp_phase_cnt.sv
// Loadable down-counter timing one SHOW or GHOST phase; tc_c marks the last cycle.
module disp_phase_cnt #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_c,
    output logic             tc_next_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload on request, otherwise count down and rest at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign tc_c      = (cnt_q == '0);
    assign tc_next_c = (cnt_d == '0);

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_W'(RST_VAL);
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/disp_scan4.sv
// Time-multiplexed 4-digit scanner feeding an MC14495 decoder, with
// frame-synchronous double buffering and leading-zero blanking.
module disp_scan4
    import disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 500,
    parameter int unsigned CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld,
    input  logic [15:0] hexs,
    input  logic [3:0]  points,
    input  logic [3:0]  les,
    input  logic        lzb,
    output logic [3:0]  an,
    output logic [3:0]  hex,
    output logic        point,
    output logic        le,
    output logic        pend,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] SHOW_LD  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GHOST_LD = CNT_W'(BLANK_CYC - 1);
    localparam disp_word_t       SHADOW_RST = '{hexs: 16'h0000, points: 4'h0, les: LES_RST};

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    disp_word_t shadow_q, shadow_d;
    disp_word_t pending_q, pending_d;
    logic       pend_q, pend_d;
    logic [3:0] an_q, an_d;
    logic [3:0] hex_q, hex_d;
    logic       point_q, point_d;
    logic       le_q, le_d;
    logic       frame_done_q, frame_done_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             tc_c;
    logic             tc_next_c;
    logic             boundary_c;
    logic [3:0]       lz_c;
    disp_word_t       live_c;

    disp_phase_cnt #(
        .CNT_W   (CNT_W),
        .RST_VAL (SCAN_DIV - 1)
    ) u_phase_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .tc_c       (tc_c),
        .tc_next_c  (tc_next_c)
    );

    assign live_c     = '{hexs: hexs, points: points, les: les};
    assign boundary_c = (state_q == GHOST) && (idx_q == 2'd3) && tc_c;

    // Next-state, load path and output decode; outputs are derived from the
    // next state so the registered values line up with the state registers.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_load     = 1'b0;
        cnt_val      = SHOW_LD;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        pend_d       = pend_q;
        an_d         = AN_OFF;
        hex_d        = hex_q;
        point_d      = point_q;
        le_d         = 1'b1;
        lz_c         = 4'h0;
        frame_done_d = 1'b0;

        if (tc_c) begin
            cnt_load = 1'b1;
            if (state_q == SHOW) begin
                state_d = GHOST;
                cnt_val = GHOST_LD;
            end else begin
                state_d = SHOW;
                idx_d   = idx_q + 2'd1;
                cnt_val = SHOW_LD;
            end
        end

        // A load on the boundary itself bypasses the pending register.
        if (boundary_c) begin
            pend_d = 1'b0;
            if (ld) begin
                shadow_d = live_c;
            end else if (pend_q) begin
                shadow_d = pending_q;
            end
        end else if (ld) begin
            pending_d = live_c;
            pend_d    = 1'b1;
        end

        lz_c = lz_mask(shadow_d.hexs) & {4{lzb}};

        if (state_d == SHOW) begin
            an_d    = ~(4'b0001 << idx_d);
            hex_d   = shadow_d.hexs[{idx_d, 2'b00} +: 4];
            point_d = shadow_d.points[idx_d];
            le_d    = shadow_d.les[idx_d] | lz_c[idx_d];
        end

        frame_done_d = (state_d == GHOST) && (idx_d == 2'd3) && tc_next_c;
    end

    // State, buffer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SHOW;
            idx_q        <= 2'd0;
            shadow_q     <= SHADOW_RST;
            pending_q    <= SHADOW_RST;
            pend_q       <= 1'b0;
            an_q         <= AN_RST;
            hex_q        <= 4'h0;
            point_q      <= 1'b0;
            le_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            pend_q       <= pend_d;
            an_q         <= an_d;
            hex_q        <= hex_d;
            point_q      <= point_d;
            le_q         <= le_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign hex        = hex_q;
    assign point      = point_q;
    assign le         = le_q;
    assign pend       = pend_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_scan4.sv
// Directed bench for disp_scan4 with SCAN_DIV=8, BLANK_CYC=2 (40-cycle frame).
module tb_disp_scan4;

    localparam int SD = 8;
    localparam int BD = 2;
    localparam int DP = SD + BD;
    localparam int FR = 4 * DP;

    typedef struct {
        logic [15:0] hexs;
        logic [3:0]  points;
        logic [3:0]  les;
        logic        lzb;
        logic        bypass;
        logic [15:0] exp_hex;
        logic [3:0]  exp_pt;
        logic [3:0]  exp_le;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld = 1'b0;
    logic [15:0] hexs = 16'h0;
    logic [3:0]  points = 4'h0;
    logic [3:0]  les = 4'h0;
    logic        lzb = 1'b0;
    logic [3:0]  an;
    logic [3:0]  hex;
    logic        point;
    logic        le;
    logic        pend;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int phase = 0;
    int fd_count = 0;

    vec_t vecs[5];
    vec_t prev;
    vec_t two_ld;

    disp_scan4 #(
        .SCAN_DIV  (SD),
        .BLANK_CYC (BD),
        .CNT_W     (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld         (ld),
        .hexs       (hexs),
        .points     (points),
        .les        (les),
        .lzb        (lzb),
        .an         (an),
        .hex        (hex),
        .point      (point),
        .le         (le),
        .pend       (pend),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (phase %0d, t=%0t)", name, act, exp, phase, $time);
        end
    endtask

    function automatic logic [3:0] exp_an(input int p);
        logic [3:0] one;
        int q;
        one = 4'b0001;
        q = p % FR;
        if ((q % DP) < SD) return ~(one << (q / DP));
        return 4'b1111;
    endfunction

    // Advance one clock; every cycle checks the anode sequence and frame pulse.
    task automatic step();
        @(posedge clk);
        #1;
        phase = (phase + 1) % FR;
        chk("an_seq", 16'(an), 16'(exp_an(phase)));
        chk("frame_done", 16'(frame_done), 16'(phase == FR - 1));
        if (frame_done) fd_count++;
    endtask

    task automatic run_to(input int target);
        for (int n = 0; n < FR && phase != target; n++) step();
    endtask

    // Walk one frame from phase 0 and check every digit's SHOW and GHOST.
    task automatic check_digits(input vec_t v);
        for (int d = 0; d < 4; d++) begin
            run_to(d * DP);
            chk("digit_an", 16'(an), 16'(exp_an(d * DP)));
            chk("digit_hex", 16'(hex), 16'(v.exp_hex[d*4 +: 4]));
            chk("digit_point", 16'(point), 16'(v.exp_pt[d]));
            chk("digit_le", 16'(le), 16'(v.exp_le[d]));
            run_to(d * DP + SD - 1);
            chk("show_end_hex", 16'(hex), 16'(v.exp_hex[d*4 +: 4]));
            chk("show_end_le", 16'(le), 16'(v.exp_le[d]));
            run_to(d * DP + SD);
            chk("ghost_hex_hold", 16'(hex), 16'(v.exp_hex[d*4 +: 4]));
            chk("ghost_point_hold", 16'(point), 16'(v.exp_pt[d]));
            chk("ghost_le", 16'(le), 16'(1'b1));
        end
    endtask

    initial begin
        vecs[0] = '{hexs: 16'h1A2F, points: 4'b0101, les: 4'b0000, lzb: 1'b0, bypass: 1'b0,
                    exp_hex: 16'h1A2F, exp_pt: 4'b0101, exp_le: 4'b0000};
        vecs[1] = '{hexs: 16'h0030, points: 4'b0000, les: 4'b0000, lzb: 1'b1, bypass: 1'b0,
                    exp_hex: 16'h0030, exp_pt: 4'b0000, exp_le: 4'b1100};
        vecs[2] = '{hexs: 16'h0000, points: 4'b0000, les: 4'b0000, lzb: 1'b1, bypass: 1'b0,
                    exp_hex: 16'h0000, exp_pt: 4'b0000, exp_le: 4'b1110};
        vecs[3] = '{hexs: 16'hBEEF, points: 4'b0000, les: 4'b0000, lzb: 1'b0, bypass: 1'b1,
                    exp_hex: 16'hBEEF, exp_pt: 4'b0000, exp_le: 4'b0000};
        vecs[4] = '{hexs: 16'h1234, points: 4'b1000, les: 4'b0101, lzb: 1'b0, bypass: 1'b0,
                    exp_hex: 16'h1234, exp_pt: 4'b1000, exp_le: 4'b0101};
        two_ld  = '{hexs: 16'h2222, points: 4'b0000, les: 4'b0000, lzb: 1'b0, bypass: 1'b0,
                    exp_hex: 16'h2222, exp_pt: 4'b0000, exp_le: 4'b0000};
        prev    = '{hexs: 16'h0000, points: 4'b0000, les: 4'b1111, lzb: 1'b0, bypass: 1'b0,
                    exp_hex: 16'h0000, exp_pt: 4'b0000, exp_le: 4'b1111};

        // Reset values while rst_n is held low.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", 16'(an), 16'(4'b1110));
        chk("rst_hex", 16'(hex), 16'(4'h0));
        chk("rst_point", 16'(point), 16'(1'b0));
        chk("rst_le", 16'(le), 16'(1'b1));
        chk("rst_pend", 16'(pend), 16'(1'b0));
        chk("rst_frame_done", 16'(frame_done), 16'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        phase = 0;

        // Two frames with no load: dark display, scan timing only.
        fd_count = 0;
        for (int n = 0; n < 2 * FR; n++) begin
            step();
            chk("dark_le", 16'(le), 16'(1'b1));
        end
        chk("fd_count", 16'(fd_count), 16'(2));

        // Table-driven loads, mid-frame or exactly on the boundary.
        for (int r = 0; r < 5; r++) begin
            if (!vecs[r].bypass) begin
                run_to(15);
                ld = 1'b1; hexs = vecs[r].hexs; points = vecs[r].points;
                les = vecs[r].les; lzb = vecs[r].lzb;
                step();
                ld = 1'b0;
                chk("pend_set", 16'(pend), 16'(1'b1));
                chk("mid_hex_unchanged", 16'(hex), 16'(prev.exp_hex[7:4]));
                chk("mid_le_unchanged", 16'(le), 16'(prev.exp_le[1]));
                run_to(FR - 1);
                chk("pend_at_boundary", 16'(pend), 16'(1'b1));
                step();
            end else begin
                run_to(FR - 1);
                ld = 1'b1; hexs = vecs[r].hexs; points = vecs[r].points;
                les = vecs[r].les; lzb = vecs[r].lzb;
                step();
                ld = 1'b0;
            end
            chk("pend_clear", 16'(pend), 16'(1'b0));
            check_digits(vecs[r]);
            prev = vecs[r];
        end

        // Two loads in one frame: the last one wins.
        run_to(12);
        ld = 1'b1; hexs = 16'h1111; points = 4'h0; les = 4'h0; lzb = 1'b0;
        step();
        ld = 1'b0;
        run_to(25);
        ld = 1'b1; hexs = 16'h2222;
        step();
        ld = 1'b0;
        chk("two_ld_pend", 16'(pend), 16'(1'b1));
        chk("two_ld_mid_hex", 16'(hex), 16'(prev.exp_hex[11:8]));
        run_to(FR - 1);
        step();
        chk("two_ld_pend_clear", 16'(pend), 16'(1'b0));
        check_digits(two_ld);

        // Asynchronous reset during digit 2 SHOW discards pending data.
        run_to(2 * DP + 2);
        ld = 1'b1; hexs = 16'h5555; points = 4'hF; les = 4'h0;
        step();
        ld = 1'b0;
        chk("pre_rst_pend", 16'(pend), 16'(1'b1));
        chk("pre_rst_le", 16'(le), 16'(1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_an", 16'(an), 16'(4'b1110));
        chk("async_rst_le", 16'(le), 16'(1'b1));
        chk("async_rst_pend", 16'(pend), 16'(1'b0));
        chk("async_rst_hex", 16'(hex), 16'(4'h0));
        repeat (3) @(posedge clk);
        #1;
        chk("held_rst_an", 16'(an), 16'(4'b1110));
        chk("held_rst_frame_done", 16'(frame_done), 16'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        phase = 0;
        for (int n = 0; n < FR + DP; n++) begin
            step();
            chk("post_rst_le", 16'(le), 16'(1'b1));
            chk("post_rst_pend", 16'(pend), 16'(1'b0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_scan4.md
Name: disp_scan4

Overview:
- Time-multiplexed 4-digit scanner sitting directly upstream of the MC14495_ZJU hex-to-7-segment decoder.
- Takes a 16-bit hex word, 4 decimal-point bits and 4 per-digit blank bits from the system.
- Cycles through the digits, driving one nibble at a time into the decoder's D3..D0 / point / LE pins together with an active-low anode select.
- Double-buffers the input so a new value only takes effect at a frame boundary, with no tearing.

Parameters:
- SCAN_DIV, 50000: clock cycles each digit is lit (SHOW phase); must be >=2.
- BLANK_CYC, 500: clock cycles of anti-ghost blanking between digits (GHOST phase); must be >=1.
- CNT_W, 16: phase-counter width; must satisfy 2^CNT_W > max(SCAN_DIV, BLANK_CYC).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ld  in  1  load strobe; samples hexs/points/les in that cycle.
- hexs  in  16  digit3..digit0 nibbles, digit0 = hexs[3:0].
- points  in  4  decimal point per digit, bit i = digit i.
- les  in  4  blank request per digit (1 = blank), bit i = digit i.
- lzb  in  1  leading-zero blanking enable, sampled live.
- an  out  4  anode select, active-low, one-hot-zero.
- hex  out  4  nibble to decoder D3..D0.
- point  out  1  to decoder point, passed unchanged.
- le  out  1  to decoder LE; 1 = blank.
- pend  out  1  a loaded value is waiting for the next frame.
- frame_done  out  1  one-cycle pulse at the end of each 4-digit frame.

Behaviour:
- All outputs are registered.
- Reset (async, rst_n=0), all values hold while rst_n is low:
  - an=4'b1110, hex=0, point=0, le=1, pend=0, frame_done=0.
  - state=SHOW, idx=0, cnt=0.
  - shadow hexs=0, shadow points=0, shadow les=4'b1111, so the display is dark until the first ld.
- State machine, states SHOW and GHOST:
  - SHOW(idx): an = ~(1<<idx); hex = shadow nibble idx; point = shadow points[idx]; le = shadow les[idx] OR lz_blank(idx).
  - SHOW lasts exactly SCAN_DIV cycles; cnt counts 0..SCAN_DIV-1, then goes to GHOST with cnt=0.
  - GHOST: an=4'b1111, le=1, hex/point hold their last values; lasts exactly BLANK_CYC cycles.
  - At the end of GHOST: idx <= (idx+1) mod 4, back to SHOW.
  - Frame period = 4*(SCAN_DIV+BLANK_CYC) cycles.
- Leading-zero blanking: lz_blank(i)=1 iff lzb=1, i>0, and shadow nibbles i..3 are all zero. Digit 0 is never lz-blanked.
- Load path:
  - A cycle with ld=1 writes hexs/points/les into the pending register and sets pend=1 on the next edge.
  - Repeated ld before a frame boundary: the last one wins.
- Frame boundary is the final GHOST cycle of idx=3. On that edge:
  - frame_done is 1 for exactly that one cycle (registered so it is visible during the boundary cycle).
  - If pend=1: shadow <= pending, pend <= 0.
  - If ld=1 in the same cycle: shadow <= the live ld inputs directly (bypass) and pend stays 0.
  - The first SHOW of digit 0 therefore always uses the new data.
- ld at any other time never changes the currently displayed digit mid-frame.
- A rst_n assert mid-frame aborts immediately to the reset values; pending data is lost.

Decomposition:
- Package disp_pkg:
  - state encoding (SHOW=1'b0, GHOST=1'b1);
  - AN_OFF=4'b1111;
  - function lz_mask(hex16) returning a 4-bit blank mask.
- One sub-module, disp_phase_cnt: a parameterised down-counter with load and terminal-count pulse, reused for both the SHOW and GHOST durations.
- Load/shadow registers and the output mux stay in the top level.

Test Plan (SCAN_DIV=8, BLANK_CYC=2 unless noted):
- Reset, then no ld for 2 frames:
  - an cycles 1110 -> 1111 -> 1101 -> 1111 -> 1011 -> 1111 -> 0111 -> 1111.
  - Each SHOW lasts 8 cycles and each GHOST 2; le=1 throughout.
  - frame_done pulses every 40 cycles.
- ld with hexs=16'h1A2F, points=4'b0101, les=0 mid-frame:
  - Displayed values unchanged until the boundary; pend=1 until then.
  - The next frame shows hex F,2,A,1 for digits 0..3, point 1,0,1,0, le=0.
- lzb=1, ld with hexs=16'h0030:
  - Digits 3 and 2 have le=1.
  - Digit 1 shows 3; digit 0 shows 0 with le=0.
  - With hexs=16'h0000, only digit 0 is lit, showing 0.
- ld asserted exactly on the boundary cycle with hexs=16'hBEEF:
  - Digit 0 SHOW in the next cycle outputs hex=F; pend stays 0.
- Two ld pulses in one frame, 16'h1111 then 16'h2222:
  - The next frame shows all digits = 2.
- rst_n pulled low for 3 cycles during idx=2 SHOW:
  - Outputs go to reset values asynchronously (an=1110, le=1).
  - Pending data is discarded; the display stays dark after release.
